if_fetch: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter. It owns the fetch PC register, issues word-addressed read requests to instruction memory, captures each returned instruction into a one-entry output register, and hands `{pc, instr}` to decode over a valid/ready handshake. Branch/jump redirects from execute reload the PC and flush in-flight work. It also drives `pc_next`, the value that feeds the PC's `pcin`.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_out_reg.sv | 37 +++
 rtl/if_fetch.sv | 123 ++++++++++++
 tb/tb_if_fetch.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM state encoding,
// sequential PC increment and the default fetch address after reset.
// No logic lives here; if_fetch and its sub-modules import this package.
package if_pkg;

    // Fetch control states: settle after reset, issue request, await response.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_t;

    // Word-addressed memory: consecutive instructions are one address apart.
    localparam int unsigned PC_STEP = 1;

    // Default fetch address after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_out_reg.sv
// One-entry {pc, instr} holding register between fetch and decode.
// Latency: a capture is visible on valid/pc/instr the cycle after it is presented.
// Backpressure: holds its entry while ready is low; flush beats capture beats drain.
module if_out_reg #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [ADDR_W-1:0] cap_pc,
    input  logic [DATA_W-1:0] cap_instr,
    input  logic              flush,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr
);

    // Flush discards the entry; a capture in the same cycle as a drain refills it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            pc    <= cap_pc;
            instr <= cap_instr;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues one word read at a time, hands {pc, instr} to decode.
// Latency: first request 1 cycle after IDLE; instruction valid the cycle after imem_rvalid.
// Backpressure: no request while the output register is full and not draining; optional
// performance counters are added by defining IF_FETCH_PERF_EN.
module if_fetch
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_instr,
`ifdef IF_FETCH_PERF_EN
    output logic [ADDR_W-1:0] pc_next,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`else
    output logic [ADDR_W-1:0] pc_next
`endif
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              drop;
    logic              fire;
    logic              capture;

    // The request depends on this cycle's id_ready, so it is decoded from the
    // registered state rather than registered itself.
    assign imem_req  = (state == S_REQ) && (!id_valid || id_ready);
    assign imem_addr = pc;
    assign pc_next   = pc + ADDR_W'(PC_STEP);
    assign fire      = imem_req && imem_gnt;

    // A response is kept only if it was not orphaned by an earlier redirect
    // and no redirect arrives alongside it.
    assign capture   = (state == S_WAIT) && imem_rvalid && !drop && !redirect_valid;

    // Fetch FSM and PC: a redirect overrides the normal sequencing and marks any
    // request still in flight so its response is thrown away.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            if (((state == S_WAIT) && !imem_rvalid) || fire) begin
                state <= S_WAIT;
                drop  <= 1'b1;
            end else begin
                // IDLE, ungranted REQ, or the in-flight response arrives now.
                state <= S_REQ;
                drop  <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (fire) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!drop) begin
                            pc <= pc_next;
                        end
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    if_out_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .cap_pc    (pc),
        .cap_instr (imem_rdata),
        .flush     (redirect_valid),
        .ready     (id_ready),
        .valid     (id_valid),
        .pc        (id_pc),
        .instr     (id_instr)
    );

`ifdef IF_FETCH_PERF_EN
    // Free-running event counters: delivered instructions and redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (id_valid && id_ready) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushed <= perf_flushed + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-cycle stimulus/expectation table plus reset sequences.
// Inputs change on the falling edge; outputs are sampled 1 ns later, before the rising edge.
// Built with or without IF_FETCH_PERF_EN.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] pc_next;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    always #5 clk = ~clk;

    if_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
`ifdef IF_FETCH_PERF_EN
        .pc_next        (pc_next),
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`else
        .pc_next        (pc_next)
`endif
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvld;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pcn;
    } vec_t;

    vec_t vt[$];
    int   checks = 0;
    int   passed = 0;

    localparam logic [31:0] I0   = 32'h1111_0000;
    localparam logic [31:0] I1   = 32'h1111_0001;
    localparam logic [31:0] I2   = 32'h1111_0002;
    localparam logic [31:0] I3   = 32'h1111_0003;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
    localparam logic [31:0] I40  = 32'h2222_0040;
    localparam logic [31:0] I80  = 32'h3333_0080;
    localparam logic [31:0] IFF  = 32'h4444_FFFF;
    localparam logic [31:0] I0B  = 32'h5555_0000;
    localparam logic [31:0] I10  = 32'h6666_0010;
    localparam logic [31:0] I11  = 32'h6666_0011;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add(input logic rv, input logic [31:0] rpc, input logic gnt,
                       input logic rvld, input logic [31:0] rdata, input logic rdy,
                       input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                       input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_pcn);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvld = rvld; v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pcn = e_pcn;
        vt.push_back(v);
    endtask

    // Called on a falling edge: drive, sample, then move to the next falling edge.
    task automatic apply(input int i);
        redirect_valid = vt[i].rv;
        redirect_pc    = vt[i].rpc;
        imem_gnt       = vt[i].gnt;
        imem_rvalid    = vt[i].rvld;
        imem_rdata     = vt[i].rdata;
        id_ready       = vt[i].rdy;
        #1;
        chk($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vt[i].e_req));
        chk($sformatf("v%0d imem_addr", i), imem_addr, vt[i].e_addr);
        chk($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(vt[i].e_vld));
        chk($sformatf("v%0d pc_next", i), pc_next, vt[i].e_pcn);
        if (vt[i].e_vld) begin
            chk($sformatf("v%0d id_pc", i), id_pc, vt[i].e_pc);
            chk($sformatf("v%0d id_instr", i), id_instr, vt[i].e_instr);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, " imem_addr"}, imem_addr, 32'd0);
        chk({tag, " id_valid"}, 32'(id_valid), 32'd0);
        chk({tag, " id_pc"}, id_pc, 32'd0);
        chk({tag, " id_instr"}, id_instr, 32'd0);
        chk({tag, " pc_next"}, pc_next, 32'd1);
`ifdef IF_FETCH_PERF_EN
        chk({tag, " perf_fetched"}, perf_fetched, 32'd0);
        chk({tag, " perf_flushed"}, perf_flushed, 32'd0);
`endif
    endtask

    // Assert reset mid-cycle, check outputs asynchronously, hold, release on a falling edge.
    task automatic mid_reset(input string tag);
        #2 reset = 1'b0;
        #1 check_reset_vals(tag);
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        id_ready       = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        //   rv  rpc    gnt rvld rdata rdy | req addr   vld id_pc  instr pc_next
        add(0, 0,     1, 0, 0,    1,  0, 0,     0, 0,     0,    1);     // 0  IDLE
        add(0, 0,     1, 0, 0,    1,  1, 0,     0, 0,     0,    1);     // 1  REQ granted
        add(0, 0,     0, 1, I0,   1,  0, 0,     0, 0,     0,    1);     // 2  WAIT, response
        for (int k = 0; k < 5; k++)
            add(0, 0, 1, 0, 0,    0,  0, 1,     1, 0,     I0,   2);     // 3-7 decode stalled
        add(0, 0,     1, 0, 0,    1,  1, 1,     1, 0,     I0,   2);     // 8  resume at 1
        add(0, 0,     0, 1, I1,   1,  0, 1,     0, 0,     0,    2);     // 9
        add(0, 0,     1, 0, 0,    1,  1, 2,     1, 1,     I1,   3);     // 10
        add(0, 0,     0, 1, I2,   1,  0, 2,     0, 0,     0,    3);     // 11
        add(0, 0,     1, 0, 0,    1,  1, 3,     1, 2,     I2,   4);     // 12
        add(0, 0,     0, 1, I3,   1,  0, 3,     0, 0,     0,    4);     // 13
        add(0, 0,     0, 0, 0,    1,  1, 4,     1, 3,     I3,   5);     // 14 ungranted
        add(0, 0,     1, 0, 0,    1,  1, 4,     0, 0,     0,    5);     // 15 granted
        add(1, 32'h40,0, 0, 0,    1,  0, 4,     0, 0,     0,    5);     // 16 redirect in WAIT
        add(0, 0,     0, 0, 0,    1,  0, 32'h40,0, 0,     0,    32'h41);// 17
        add(0, 0,     0, 1, JUNK, 1,  0, 32'h40,0, 0,     0,    32'h41);// 18 stale response
        add(0, 0,     1, 0, 0,    1,  1, 32'h40,0, 0,     0,    32'h41);// 19
        add(0, 0,     0, 1, I40,  1,  0, 32'h40,0, 0,     0,    32'h41);// 20
        add(0, 0,     1, 0, 0,    1,  1, 32'h41,1, 32'h40,I40,  32'h42);// 21
        add(1, 32'h80,0, 1, JUNK, 1,  0, 32'h41,0, 0,     0,    32'h42);// 22 redirect + rvalid
        add(0, 0,     1, 0, 0,    1,  1, 32'h80,0, 0,     0,    32'h81);// 23
        add(0, 0,     0, 1, I80,  1,  0, 32'h80,0, 0,     0,    32'h81);// 24 kept
        add(1, ONES,  1, 0, 0,    1,  1, 32'h81,1, 32'h80,I80,  32'h82);// 25 redirect + grant
        add(0, 0,     0, 1, JUNK, 1,  0, ONES,  0, 0,     0,    0);     // 26 stale response
        add(0, 0,     1, 0, 0,    1,  1, ONES,  0, 0,     0,    0);     // 27
        add(0, 0,     0, 1, IFF,  1,  0, ONES,  0, 0,     0,    0);     // 28
        add(0, 0,     1, 0, 0,    1,  1, 0,     1, ONES,  IFF,  1);     // 29 wrapped
        add(0, 0,     0, 1, I0B,  1,  0, 0,     0, 0,     0,    1);     // 30
        add(0, 0,     1, 0, 0,    0,  0, 1,     1, 0,     I0B,  2);     // 31 stalled
        add(1, 32'h10,1, 0, 0,    0,  0, 1,     1, 0,     I0B,  2);     // 32 redirect, no req
        add(0, 0,     1, 0, 0,    1,  1, 32'h10,0, 0,     0,    32'h11);// 33
        add(0, 0,     0, 1, I10,  1,  0, 32'h10,0, 0,     0,    32'h11);// 34
        add(0, 0,     1, 0, 0,    1,  1, 32'h11,1, 32'h10,I10,  32'h12);// 35
        add(0, 0,     0, 0, 0,    1,  0, 32'h11,0, 0,     0,    32'h12);// 36 memory latency
        add(0, 0,     0, 1, I11,  1,  0, 32'h11,0, 0,     0,    32'h12);// 37
        add(0, 0,     0, 0, 0,    0,  0, 32'h12,1, 32'h11,I11,  32'h13);// 38 holding entry

        repeat (2) @(negedge clk);
        #1 check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < vt.size(); i++) apply(i);

`ifdef IF_FETCH_PERF_EN
        chk("perf_fetched total", perf_fetched, 32'd8);
        chk("perf_flushed total", perf_flushed, 32'd4);
`endif

        // Reset while the output register holds an instruction.
        mid_reset("rst_full");
        apply(0);
        apply(1);
        // Reset with a request outstanding (state WAIT).
        mid_reset("rst_wait");
        for (int i = 0; i < 5; i++) apply(i);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
